// File: rtl/reg_to_axi_lite_bridge.sv
// RegBus slave to AXI-Lite master bridge: one command in flight, replayed as a
// single AXI-Lite read or write, completed back on RegBus with rdata/error.

package reg_to_axi_lite_bridge_pkg;
   localparam int unsigned AddrWidth = 32;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned StrbWidth = DataWidth / 8;

   typedef struct packed {
      logic                 valid;
      logic                 write;
      logic [AddrWidth-1:0] addr;
      logic [DataWidth-1:0] wdata;
      logic [StrbWidth-1:0] wstrb;
   } reg_req_t;

   typedef struct packed {
      logic                 ready;
      logic [DataWidth-1:0] rdata;
      logic                 error;
   } reg_rsp_t;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic [2:0]           prot;
   } axi_lite_ax_t;

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic [StrbWidth-1:0] strb;
   } axi_lite_w_t;

   typedef struct packed {
      logic [1:0] resp;
   } axi_lite_b_t;

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic [1:0]           resp;
   } axi_lite_r_t;

   typedef struct packed {
      axi_lite_ax_t aw;
      logic         aw_valid;
      axi_lite_w_t  w;
      logic         w_valid;
      logic         b_ready;
      axi_lite_ax_t ar;
      logic         ar_valid;
      logic         r_ready;
   } axi_lite_req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        w_ready;
      axi_lite_b_t b;
      logic        b_valid;
      logic        ar_ready;
      axi_lite_r_t r;
      logic        r_valid;
   } axi_lite_rsp_t;
endpackage

// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; a valid, once raised, holds with a stable payload until that edge.
module reg_to_axi_lite_bridge #(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter type         reg_req_t      = reg_to_axi_lite_bridge_pkg::reg_req_t,
   parameter type         reg_rsp_t      = reg_to_axi_lite_bridge_pkg::reg_rsp_t,
   parameter type         axi_lite_req_t = reg_to_axi_lite_bridge_pkg::axi_lite_req_t,
   parameter type         axi_lite_rsp_t = reg_to_axi_lite_bridge_pkg::axi_lite_rsp_t
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  reg_req_t      reg_req_i,
   output reg_rsp_t      reg_rsp_o,
   output axi_lite_req_t axi_lite_req_o,
   input  axi_lite_rsp_t axi_lite_rsp_i,
   output logic [2:0]    o_dbg_state
);

   localparam int unsigned StrbWidth = DataWidth / 8;

   // Debug encoding: IDLE=0, WRITE=1, WR_RESP=2, RD_ADDR=3, RD_DATA=4, DONE=5.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WRITE   = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_ADDR = 3'd3,
      S_RD_DATA = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   state_e                 r_state;
   logic                   r_aw_pend;
   logic                   r_w_pend;
   logic                   r_ar_valid;
   logic                   r_b_ready;
   logic                   r_r_ready;
   logic                   r_ready;
   logic                   r_error;
   logic [DataWidth-1:0]   r_rdata;
   logic [AddrWidth-1:0]   r_addr;
   logic [DataWidth-1:0]   r_wdata;
   logic [StrbWidth-1:0]   r_wstrb;

   logic                   w_aw_left;
   logic                   w_w_left;

   // A pend flag survives the edge only if its handshake did not happen now.
   assign w_aw_left = r_aw_pend & ~axi_lite_rsp_i.aw_ready;
   assign w_w_left  = r_w_pend  & ~axi_lite_rsp_i.w_ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_aw_pend  <= 1'b0;
         r_w_pend   <= 1'b0;
         r_ar_valid <= 1'b0;
         r_b_ready  <= 1'b0;
         r_r_ready  <= 1'b0;
         r_ready    <= 1'b0;
         r_error    <= 1'b0;
         r_rdata    <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (reg_req_i.valid) begin
                  r_addr  <= reg_req_i.addr;
                  r_wdata <= reg_req_i.wdata;
                  r_wstrb <= reg_req_i.wstrb;
                  if (reg_req_i.write) begin
                     r_aw_pend <= 1'b1;
                     r_w_pend  <= 1'b1;
                     r_state   <= S_WRITE;
                  end else begin
                     r_ar_valid <= 1'b1;
                     r_state    <= S_RD_ADDR;
                  end
               end
            end
            S_WRITE: begin
               r_aw_pend <= w_aw_left;
               r_w_pend  <= w_w_left;
               if (!w_aw_left && !w_w_left) begin
                  r_b_ready <= 1'b1;
                  r_state   <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (axi_lite_rsp_i.b_valid) begin
                  r_b_ready <= 1'b0;
                  r_error   <= (axi_lite_rsp_i.b.resp != 2'b00);
                  r_rdata   <= '0;
                  r_ready   <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_RD_ADDR: begin
               if (axi_lite_rsp_i.ar_ready) begin
                  r_ar_valid <= 1'b0;
                  r_r_ready  <= 1'b1;
                  r_state    <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (axi_lite_rsp_i.r_valid) begin
                  r_r_ready <= 1'b0;
                  r_rdata   <= axi_lite_rsp_i.r.data;
                  r_error   <= (axi_lite_rsp_i.r.resp != 2'b00);
                  r_ready   <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               // The upstream valid is still high here; IDLE samples next cycle.
               r_ready <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      axi_lite_req_o          = '0;
      axi_lite_req_o.aw.addr  = r_addr;
      axi_lite_req_o.aw.prot  = 3'b000;
      axi_lite_req_o.aw_valid = r_aw_pend;
      axi_lite_req_o.w.data   = r_wdata;
      axi_lite_req_o.w.strb   = r_wstrb;
      axi_lite_req_o.w_valid  = r_w_pend;
      axi_lite_req_o.b_ready  = r_b_ready;
      axi_lite_req_o.ar.addr  = r_addr;
      axi_lite_req_o.ar.prot  = 3'b000;
      axi_lite_req_o.ar_valid = r_ar_valid;
      axi_lite_req_o.r_ready  = r_r_ready;
   end

   always_comb begin
      reg_rsp_o       = '0;
      reg_rsp_o.ready = r_ready;
      reg_rsp_o.rdata = r_rdata;
      reg_rsp_o.error = r_error;
   end

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reg_to_axi_lite_bridge.sv
// Bench for reg_to_axi_lite_bridge: directed and random RegBus commands against
// a reactive AXI-Lite slave, checked against a cycle-count reference model.
module tb_reg_to_axi_lite_bridge;
  import reg_to_axi_lite_bridge_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  reg_req_t      req;
  reg_rsp_t      rsp;
  axi_lite_req_t axq;
  axi_lite_rsp_t axr;
  logic [2:0]    dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  reg_to_axi_lite_bridge dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .reg_req_i      (req),
    .reg_rsp_o      (rsp),
    .axi_lite_req_o (axq),
    .axi_lite_rsp_i (axr),
    .o_dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: cycle (counted from the command-sample cycle 0) where ready=1.
  function automatic int exp_ready_cyc(input bit wr, input int aw_w, input int w_w,
                                       input int b_w, input int ar_w, input int r_w);
    int aw_c, w_c;
    if (wr) begin
      aw_c = 1 + aw_w;
      w_c  = 1 + w_w;
      return ((aw_c > w_c) ? aw_c : w_c) + 1 + b_w + 1;
    end
    return (1 + ar_w) + 1 + r_w + 1;
  endfunction

  task automatic idle_outputs(input string tag);
    check({tag, " aw_valid"}, axq.aw_valid, 1'b0);
    check({tag, " w_valid"},  axq.w_valid,  1'b0);
    check({tag, " ar_valid"}, axq.ar_valid, 1'b0);
    check({tag, " b_ready"},  axq.b_ready,  1'b0);
    check({tag, " r_ready"},  axq.r_ready,  1'b0);
    check({tag, " ready"},    rsp.ready,    1'b0);
    check({tag, " state"},    dbg_state,    3'd0);
  endtask

  // Called at a negedge. offset=1 when the command is presented during DONE.
  task automatic run_txn(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int aw_w, input int w_w, input int b_w,
                         input int ar_w, input int r_w,
                         input logic [1:0] resp, input logic [31:0] rdata,
                         input bit drop, input bit chain, input int offset,
                         input bit abort);
    bit aw_done = 0, w_done = 0, b_done = 0, ar_done = 0, r_done = 0;
    int aw_seen = 0, w_seen = 0, ar_seen = 0, b_cnt = 0, r_cnt = 0;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int first_v = -1, w_after = 0, rdy_cyc = -1;
    bit got_ready = 0;
    bit bd, rd;
    logic [31:0] cap_addr = '0, cap_data = '0, obs_rdata = '0;
    logic [3:0]  cap_strb = '0;
    logic [2:0]  cap_prot = 3'h7;
    logic        obs_err = 1'bx;
    logic [31:0] e_rdata;

    req.valid = 1'b1; req.write = wr; req.addr = addr; req.wdata = wdata; req.wstrb = strb;
    axr = '0;
    for (int k = 1; k <= 80 && !got_ready; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (drop) req.valid = 1'b0;
      if (abort && axq.b_ready) begin
        rst_n = 1'b0;
        #1;
        idle_outputs({tag, " in-reset"});
        req.valid = 1'b0;
        axr = '0;
        return;
      end
      if (first_v < 0 && (axq.aw_valid || axq.ar_valid)) first_v = k;
      if (w_done && axq.w_valid) w_after++;
      bd = aw_done && w_done && !b_done;
      rd = ar_done && !r_done;
      // B and R become eligible only after the address/data phases completed earlier
      axr.b.resp = resp;
      axr.b_valid = 1'b0;
      if (bd) begin
        if (b_cnt >= b_w) axr.b_valid = 1'b1;
        else b_cnt++;
      end
      axr.r.data = rdata;
      axr.r.resp = resp;
      axr.r_valid = 1'b0;
      if (rd) begin
        if (r_cnt >= r_w) axr.r_valid = 1'b1;
        else r_cnt++;
      end
      axr.aw_ready = axq.aw_valid && !aw_done && (aw_seen >= aw_w);
      if (axq.aw_valid && !aw_done && !axr.aw_ready) aw_seen++;
      axr.w_ready = axq.w_valid && !w_done && (w_seen >= w_w);
      if (axq.w_valid && !w_done && !axr.w_ready) w_seen++;
      axr.ar_ready = axq.ar_valid && !ar_done && (ar_seen >= ar_w);
      if (axq.ar_valid && !ar_done && !axr.ar_ready) ar_seen++;
      if (axr.b_valid && axq.b_ready) begin n_b++; b_done = 1; end
      if (axr.r_valid && axq.r_ready) begin n_r++; r_done = 1; end
      if (axq.aw_valid && axr.aw_ready) begin
        n_aw++; aw_done = 1; cap_addr = axq.aw.addr; cap_prot = axq.aw.prot;
      end
      if (axq.w_valid && axr.w_ready) begin
        n_w++; w_done = 1; cap_data = axq.w.data; cap_strb = axq.w.strb;
      end
      if (axq.ar_valid && axr.ar_ready) begin
        n_ar++; ar_done = 1; cap_addr = axq.ar.addr; cap_prot = axq.ar.prot;
      end
      if (rsp.ready) begin
        got_ready = 1; rdy_cyc = k; obs_rdata = rsp.rdata; obs_err = rsp.error;
      end
    end
    e_rdata = wr ? 32'h0 : rdata;
    check({tag, " completed"}, got_ready, 1'b1);
    check({tag, " ready cycle"}, rdy_cyc, exp_ready_cyc(wr, aw_w, w_w, b_w, ar_w, r_w) + offset);
    check({tag, " first axi valid"}, first_v, 1 + offset);
    check({tag, " rdata"}, obs_rdata, e_rdata);
    check({tag, " error"}, obs_err, resp != 2'b00);
    check({tag, " aw count"}, n_aw, wr ? 1 : 0);
    check({tag, " w count"},  n_w,  wr ? 1 : 0);
    check({tag, " b count"},  n_b,  wr ? 1 : 0);
    check({tag, " ar count"}, n_ar, wr ? 0 : 1);
    check({tag, " r count"},  n_r,  wr ? 0 : 1);
    check({tag, " addr"}, cap_addr, addr);
    check({tag, " prot"}, cap_prot, 3'b000);
    if (wr) begin
      check({tag, " wdata"}, cap_data, wdata);
      check({tag, " wstrb"}, cap_strb, strb);
      check({tag, " w_valid after hs"}, w_after, 0);
    end
    axr = '0;
    if (!chain) begin
      req.valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({tag, " ready pulse"}, rsp.ready, 1'b0);
      check({tag, " axi idle"}, {axq.aw_valid, axq.w_valid, axq.ar_valid}, 3'b000);
      check({tag, " rdata hold"}, rsp.rdata, e_rdata);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    axr   = '0;
    repeat (3) @(negedge clk);
    idle_outputs("reset");
    check("reset rdata", rsp.rdata, 32'h0);
    check("reset error", rsp.error, 1'b0);
    check("reset payload", {axq.aw.addr, axq.w.data, axq.w.strb, axq.ar.addr}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn("wr zero-wait", 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF,
            0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0, 0, 0);
    run_txn("rd r-wait5", 0, 32'h0000_2004, 32'h0, 4'h0,
            0, 0, 0, 0, 5, 2'b00, 32'h1234_5678, 0, 0, 0, 0);
    run_txn("wr w-first", 1, 32'h0000_3008, 32'h0BAD_F00D, 4'h5,
            3, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0, 0, 0);
    run_txn("rd slverr", 0, 32'h0000_400C, 32'h0, 4'h0,
            0, 0, 0, 1, 0, 2'b10, 32'hA5A5_A5A5, 0, 0, 0, 0);
    run_txn("wr decerr", 1, 32'h0000_5010, 32'h1111_2222, 4'h3,
            1, 2, 1, 0, 0, 2'b11, 32'h0, 0, 0, 0, 0);
    run_txn("b2b rd", 0, 32'h0000_6000, 32'h0, 4'h0,
            0, 0, 0, 0, 0, 2'b00, 32'hCAFE_0001, 0, 1, 0, 0);
    run_txn("b2b wr", 1, 32'h0000_6004, 32'h7777_8888, 4'hC,
            0, 0, 0, 0, 0, 2'b01, 32'h0, 0, 0, 1, 0);
    run_txn("rd valid-drop", 0, 32'h0000_7000, 32'h0, 4'h0,
            2, 0, 0, 2, 1, 2'b00, 32'h5A5A_0F0F, 1, 0, 0, 0);

    // Unsolicited responses in IDLE must be left stalled
    axr.b_valid = 1'b1;
    axr.r_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("unsolicited b_ready", axq.b_ready, 1'b0);
    check("unsolicited r_ready", axq.r_ready, 1'b0);
    check("unsolicited state", dbg_state, 3'd0);
    axr = '0;
    @(negedge clk);

    run_txn("wr reset-abort", 1, 32'h0000_8000, 32'h0123_4567, 4'hF,
            0, 0, 4, 0, 0, 2'b00, 32'h0, 0, 0, 0, 1);
    @(negedge clk);
    idle_outputs("held reset");
    rst_n = 1'b1;
    @(negedge clk);
    run_txn("rd after reset", 0, 32'h0000_8004, 32'h0, 4'h0,
            0, 0, 0, 0, 0, 2'b00, 32'h89AB_CDEF, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      run_txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), $urandom, $urandom,
              4'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
